// File: rtl/pulse_param_loader_if.sv
// Host byte link into the pulse parameter loader: one byte per rx_valid strobe.
interface pulse_param_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/pulse_param_loader.sv
// Framed host writes into shadow pulse-timing registers, validated commit,
// and atomic transfer to the active outputs immediately or on a sync_in rising edge.
module pulse_param_loader #(
    parameter int unsigned TIMEOUT = 32'd200000
) (
    input  logic                 clk_pll,
    input  logic                 reset,
    pulse_param_loader_if.slave  rx,
    input  logic                 sync_in,
    output logic [31:0]          per,
    output logic [31:0]          p1wid,
    output logic [31:0]          del,
    output logic [31:0]          p2wid,
    output logic [7:0]           p_bl,
    output logic [15:0]          p_bl_off,
    output logic                 pu,
    output logic                 cp,
    output logic                 bl,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic                 applied,
    output logic                 commit_pending
);

    localparam int unsigned GAP_LAST = TIMEOUT - 1;
    localparam logic [7:0]  HDR      = 8'hA5;
    localparam logic [7:0]  A_FLAGS  = 8'h07;
    localparam logic [7:0]  A_COMMIT = 8'h0F;

    localparam logic [31:0] RST_PER   = 32'd200000;
    localparam logic [31:0] RST_P1WID = 32'd60;
    localparam logic [31:0] RST_DEL   = 32'd200;
    localparam logic [31:0] RST_P2WID = 32'd120;
    localparam logic [7:0]  RST_P_BL  = 8'd10;
    localparam logic [15:0] RST_P_OFF = 16'd100;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] gap_q, gap_d;

    logic [31:0] sh_per, sh_p1wid, sh_del, sh_p2wid;
    logic [7:0]  sh_p_bl;
    logic [15:0] sh_p_bl_off;
    logic        sh_pu, sh_cp, sh_bl;

    logic        sync_q, sync_q2, imm_q;
    logic        exec_c, wr_c, arm_c, ok_c, err_c;
    logic        rise_c, apply_c, valid_c;
    logic [33:0] sum_c;

    // Commit check in 34 bits so large widths cannot wrap past per
    assign sum_c   = 34'(sh_p1wid) + 34'(sh_del) + 34'(sh_p2wid) + 34'(sh_del);
    assign valid_c = !sh_cp || (sum_c < 34'(sh_per));
    assign rise_c  = sync_q & ~sync_q2;
    assign apply_c = commit_pending & (imm_q | rise_c);

    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            addr_q     <= 8'd0;
            data_q     <= 32'd0;
            csum_q     <= 8'd0;
            gap_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            csum_q     <= csum_d;
            gap_q      <= gap_d;
        end
    end

    // Frame parser: advances only on rx_valid; 0xA5 past the header is plain data
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        csum_d     = csum_q;
        gap_d      = (rx.rx_valid || state_q == IDLE) ? 32'd0 : gap_q + 32'd1;
        exec_c     = 1'b0;
        wr_c       = 1'b0;
        arm_c      = 1'b0;
        ok_c       = 1'b0;
        err_c      = 1'b0;

        if (rx.rx_valid) begin
            unique case (state_q)
                IDLE: if (rx.rx_data == HDR) state_d = ADDR;
                ADDR: begin
                    addr_d     = rx.rx_data;
                    csum_d     = rx.rx_data;
                    byte_cnt_d = 2'd0;
                    state_d    = DATA;
                end
                DATA: begin
                    data_d     = {data_q[23:0], rx.rx_data};
                    csum_d     = csum_q ^ rx.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = CSUM;
                end
                CSUM: begin
                    state_d = IDLE;
                    if (rx.rx_data == csum_q) exec_c = 1'b1;
                    else                      err_c  = 1'b1;
                end
            endcase
        end else if (state_q != IDLE && gap_q >= GAP_LAST) begin
            state_d = IDLE;
            gap_d   = 32'd0;
            err_c   = 1'b1;
        end

        if (exec_c) begin
            if (addr_q >= 8'h01 && addr_q <= A_FLAGS) begin
                wr_c = 1'b1;
                ok_c = 1'b1;
            end else if (addr_q == A_COMMIT) begin
                arm_c = valid_c;
                ok_c  = valid_c;
                err_c = !valid_c;
            end else begin
                err_c = 1'b1;
            end
        end
    end

    // Shadow/active registers; apply reads shadow before any same-cycle write lands
    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            sh_per         <= RST_PER;
            sh_p1wid       <= RST_P1WID;
            sh_del         <= RST_DEL;
            sh_p2wid       <= RST_P2WID;
            sh_p_bl        <= RST_P_BL;
            sh_p_bl_off    <= RST_P_OFF;
            sh_pu          <= 1'b1;
            sh_cp          <= 1'b1;
            sh_bl          <= 1'b1;
            per            <= RST_PER;
            p1wid          <= RST_P1WID;
            del            <= RST_DEL;
            p2wid          <= RST_P2WID;
            p_bl           <= RST_P_BL;
            p_bl_off       <= RST_P_OFF;
            pu             <= 1'b1;
            cp             <= 1'b1;
            bl             <= 1'b1;
            frame_ok       <= 1'b0;
            frame_err      <= 1'b0;
            applied        <= 1'b0;
            commit_pending <= 1'b0;
            imm_q          <= 1'b0;
            sync_q         <= 1'b0;
            sync_q2        <= 1'b0;
        end else begin
            frame_ok  <= ok_c;
            frame_err <= err_c;
            applied   <= apply_c;
            sync_q    <= sync_in;
            sync_q2   <= sync_q;

            if (arm_c) begin
                commit_pending <= 1'b1;
                imm_q          <= data_q[0];
            end else if (apply_c) begin
                commit_pending <= 1'b0;
                imm_q          <= 1'b0;
            end

            if (apply_c) begin
                per      <= sh_per;
                p1wid    <= sh_p1wid;
                del      <= sh_del;
                p2wid    <= sh_p2wid;
                p_bl     <= sh_p_bl;
                p_bl_off <= sh_p_bl_off;
                pu       <= sh_pu;
                cp       <= sh_cp;
                bl       <= sh_bl;
            end

            if (wr_c) begin
                case (addr_q)
                    8'h01:   sh_per      <= data_q;
                    8'h02:   sh_p1wid    <= data_q;
                    8'h03:   sh_del      <= data_q;
                    8'h04:   sh_p2wid    <= data_q;
                    8'h05:   sh_p_bl     <= data_q[7:0];
                    8'h06:   sh_p_bl_off <= data_q[15:0];
                    A_FLAGS: {sh_bl, sh_cp, sh_pu} <= data_q[2:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/pulse_param_loader.md
PULSE_PARAM_LOADER -- requirements
Module: pulse_param_loader

Interface
REQ-001 Parameter TIMEOUT, default 32'd200000, meaning max clk_pll cycles allowed between bytes inside one frame.
REQ-002 clk_pll  input  1  200 MHz PLL clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous active-low reset.
REQ-004 rx_data  input  8  received byte from the host link.
REQ-005 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-006 sync_in  input  1  scope trigger from the pulse generator; its rising edge marks a period boundary.
REQ-007 per, p1wid, del, p2wid  output  32 each  active period and timing words for the pulse generator.
REQ-008 p_bl  output  8; p_bl_off  output  16; pu, cp, bl  output  1 each  active block and mode settings.
REQ-009 frame_ok, frame_err, applied  output  1 each  one-cycle status strobes.
REQ-010 commit_pending  output  1  high while a validated commit waits for a period boundary.

Function
REQ-011 Frame format SHALL be: header 0xA5, address byte, four data bytes MSB first, then checksum equal to the XOR of address and the four data bytes.
REQ-012 The FSM SHALL have states IDLE, ADDR, DATA, CSUM, and SHALL transition only on cycles with rx_valid=1.
- IDLE->ADDR on byte 0xA5; any other byte stays in IDLE silently.
- ADDR->DATA; data byte counter reset to 0.
- DATA->CSUM after the 4th byte.
- CSUM->IDLE always.
REQ-013 In CSUM, a checksum match SHALL raise frame_ok for one cycle on the following cycle and execute the address; a mismatch SHALL raise frame_err and write nothing.
REQ-014 Address map, writing shadow registers only:
- 0x01 per; 0x02 p1wid; 0x03 del; 0x04 p2wid.
- 0x05 p_bl = data[7:0]; 0x06 p_bl_off = data[15:0].
- 0x07 flags: bit0 pu, bit1 cp, bit2 bl.
- 0x0F commit.
- Any other address: frame_err; no write.
REQ-015 On commit, validate shadow values before arming:
- Test: p1wid+del+p2wid+del < per, evaluated in 34-bit arithmetic with no wrap.
- Pass: arm the commit and set commit_pending.
- Fail: raise frame_err, leave commit_pending clear, keep active outputs unchanged.
- Validation is skipped when shadow cp=0 (CW mode).
REQ-016 Apply timing: with commit data bit0=1, the commit SHALL apply immediately, on the cycle after the commit frame's frame_ok.
REQ-017 Otherwise the commit SHALL apply on the first rising edge of sync_in detected after arming. Edge detection uses a registered copy of sync_in, so apply occurs one cycle after the sample in which sync_in is first seen high.
REQ-018 Apply SHALL copy all shadow registers to the active outputs in a single cycle, pulse applied, and clear commit_pending.
REQ-019 Active outputs SHALL change only on an apply cycle or on reset.
REQ-020 A new commit arriving while commit_pending=1 SHALL re-validate and re-arm using current shadow contents; a single later apply carries the newest values.
REQ-021 Shadow writes while commit_pending=1 SHALL be accepted, and the pending apply SHALL use the shadow contents present on the apply cycle.
REQ-022 Inter-byte timeout: in ADDR, DATA or CSUM, if TIMEOUT cycles elapse without rx_valid, the FSM SHALL return to IDLE and pulse frame_err; the gap counter resets on every rx_valid.
REQ-023 A 0xA5 byte in ADDR, DATA or CSUM SHALL be treated as data, never as a resync.
REQ-024 Simultaneous apply and shadow write on the same cycle: apply SHALL use the pre-write shadow value.
REQ-025 frame_ok, frame_err and applied SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-026 reset=0 SHALL force, on the next edge:
- FSM to IDLE; byte and gap counters to 0; commit_pending=0; all strobes 0.
- Active and shadow registers to: per=200000, p1wid=60, del=200, p2wid=120, p_bl=10, p_bl_off=100, pu=1, cp=1, bl=1.
REQ-027 Reset asserted mid-frame or with commit_pending=1 SHALL discard the partial frame and the pending commit.

Verification
REQ-028 Frame A5 01 00 03 0D 40 4F, then commit A5 0F 00 00 00 01 0E -> frame_ok twice; per=200000 until applied, then per=0x00030D40 with applied pulsing once.
REQ-029 Write p1wid=0x00030D40 (per=200000, del=200, p2wid=120), then a commit with bit0=1 -> frame_err; p1wid stays 60; commit_pending stays 0.
REQ-030 Deferred commit A5 0F 00 00 00 00 0F with sync_in low for 500 cycles, then sync_in rising -> commit_pending high throughout; outputs update exactly one cycle after the edge is sampled.
REQ-031 Send A5 02 00 00, then idle for TIMEOUT cycles -> one frame_err pulse; FSM in IDLE; the next valid frame is accepted.
REQ-032 Frame with a bad checksum byte (0x00 instead of 0x4F) -> frame_err; no shadow change; a later commit applies the old values.
REQ-033 Assert reset during the DATA state with commit_pending=1 -> all outputs return to reset values; commit_pending=0; no applied pulse.
